// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester, RAM and stall signal bundle for mem_arbiter
//
// Purpose: groups every non-clock/reset signal of the unified byte-RAM arbiter.
//   The master modport is the pipeline/RAM side and the slave modport is the arbiter.
// Optional: MEM_ARB_ALIGN_CHECK_EN adds mem_misalign_o.
// Signals:
//   if_req_i/if_addr_i/if_cancel_i      fetch request, word address, abort
//   if_data_o/if_done_o                 fetched word and its one-cycle done pulse
//   mem_req_i/mem_we_i/mem_width_i      load/store request, store flag, 0=B 1=H 2/3=W
//   mem_signed_i/mem_addr_i/mem_wdata_i sign-extend flag, byte address, store data
//   mem_rdata_o/mem_done_o              extended load result and its done pulse
//   ram_a_o/ram_dout_o/ram_wr_o         byte RAM address, write data, write strobe
//   ram_din_i                           byte RAM read data, one cycle after address
//   stall_req_o                         pipeline stall while a request is outstanding
interface mem_arbiter_if #(
    parameter int ADDR_W = 17
);
    logic              if_req_i;
    logic [31:0]       if_addr_i;
    logic              if_cancel_i;
    logic [31:0]       if_data_o;
    logic              if_done_o;
    logic              mem_req_i;
    logic              mem_we_i;
    logic [1:0]        mem_width_i;
    logic              mem_signed_i;
    logic [31:0]       mem_addr_i;
    logic [31:0]       mem_wdata_i;
    logic [31:0]       mem_rdata_o;
    logic              mem_done_o;
    logic [ADDR_W-1:0] ram_a_o;
    logic [7:0]        ram_dout_o;
    logic              ram_wr_o;
    logic [7:0]        ram_din_i;
    logic              stall_req_o;
`ifdef MEM_ARB_ALIGN_CHECK_EN
    logic              mem_misalign_o;
`endif

    modport master (
        output if_req_i, if_addr_i, if_cancel_i,
        output mem_req_i, mem_we_i, mem_width_i, mem_signed_i, mem_addr_i, mem_wdata_i,
        output ram_din_i,
        input  if_data_o, if_done_o, mem_rdata_o, mem_done_o,
        input  ram_a_o, ram_dout_o, ram_wr_o, stall_req_o
`ifdef MEM_ARB_ALIGN_CHECK_EN
        , input mem_misalign_o
`endif
    );

    modport slave (
        input  if_req_i, if_addr_i, if_cancel_i,
        input  mem_req_i, mem_we_i, mem_width_i, mem_signed_i, mem_addr_i, mem_wdata_i,
        input  ram_din_i,
        output if_data_o, if_done_o, mem_rdata_o, mem_done_o,
        output ram_a_o, ram_dout_o, ram_wr_o, stall_req_o
`ifdef MEM_ARB_ALIGN_CHECK_EN
        , output mem_misalign_o
`endif
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester sequencer for a single byte-wide unified RAM
//
// Purpose: shares one byte RAM port between instruction fetch and load/store,
//   splitting 8/16/32-bit accesses into little-endian byte cycles, assembling and
//   extending read data, and stalling the pipeline while any request is outstanding.
// Optional: MEM_ARB_ALIGN_CHECK_EN rejects misaligned half/word load/stores in one
//   cycle and reports them on mem_misalign_o.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  mem_arbiter_if.slave: fetch, load/store, RAM and stall signals
module mem_arbiter #(
    parameter int ADDR_W = 17
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;

    logic              owner_mem;  // 1: load/store owns the port, 0: fetch
    logic              we;
    logic              sgn;
    logic [1:0]        width;
    logic [1:0]        last_k;     // index of the final byte (N-1)
    logic [1:0]        k;          // byte currently on the RAM address
    logic [ADDR_W-1:0] base;
    logic [31:0]       wdata;
    logic [31:0]       asm_data;
    logic              misalign;

    logic              grant_mem;
    logic              grant_if;
    logic              if_cancel_own;
    logic              req_misalign;
    logic              xfer;
    logic              cap_en;
    logic [1:0]        cap_idx;
    logic [31:0]       load_ext;
    logic              if_done;
    logic              mem_done;
    logic              unused_addr_hi;

    // Only the low ADDR_W address bits reach the RAM.
    assign unused_addr_hi = ^{bus.if_addr_i[31:ADDR_W], bus.mem_addr_i[31:ADDR_W]};

    function automatic logic [1:0] last_index(input logic [1:0] w);
        case (w)
            2'd0:    return 2'd0;
            2'd1:    return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

`ifdef MEM_ARB_ALIGN_CHECK_EN
    // Width 3 is a word, so bit 1 of the width marks word accesses.
    assign req_misalign = ((bus.mem_width_i == 2'd1) && bus.mem_addr_i[0]) ||
                          (bus.mem_width_i[1] && (bus.mem_addr_i[1:0] != 2'b00));
`else
    assign req_misalign = 1'b0;
`endif

    // A cancel only matters while the fetch owns the port; MEM is never aborted.
    assign if_cancel_own = !owner_mem && bus.if_cancel_i;

    always_comb begin
        state_next = state;
        grant_mem  = 1'b0;
        grant_if   = 1'b0;
        case (state)
            IDLE: begin
                // Load/store belongs to the older instruction, so it wins.
                if (bus.mem_req_i) begin
                    grant_mem  = 1'b1;
                    state_next = req_misalign ? DONE : XFER;
                end else if (bus.if_req_i && !bus.if_cancel_i) begin
                    grant_if   = 1'b1;
                    state_next = XFER;
                end
            end
            XFER: begin
                if (if_cancel_own) begin
                    state_next = IDLE;
                end else if (k == last_k) begin
                    // Stores have nothing to capture, so they skip DRAIN.
                    state_next = we ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                state_next = if_cancel_own ? IDLE : DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign xfer = (state == XFER);

    // RAM data lags the address by one cycle: byte k-1 arrives while byte k is
    // addressed, and the final byte arrives in DRAIN.
    assign cap_en  = (xfer && (k != 2'd0)) || (state == DRAIN);
    assign cap_idx = (state == DRAIN) ? last_k : (k - 2'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner_mem <= 1'b0;
            we        <= 1'b0;
            sgn       <= 1'b0;
            width     <= 2'd0;
            last_k    <= 2'd0;
            k         <= 2'd0;
            base      <= '0;
            wdata     <= 32'd0;
            asm_data  <= 32'd0;
            misalign  <= 1'b0;
        end else begin
            state <= state_next;
            if (grant_mem || grant_if) begin
                owner_mem <= grant_mem;
                we        <= grant_mem & bus.mem_we_i;
                sgn       <= grant_mem & bus.mem_signed_i;
                width     <= grant_mem ? bus.mem_width_i : 2'd2;
                last_k    <= last_index(grant_mem ? bus.mem_width_i : 2'd2);
                base      <= grant_mem ? bus.mem_addr_i[ADDR_W-1:0]
                                       : bus.if_addr_i[ADDR_W-1:0];
                wdata     <= bus.mem_wdata_i;
                misalign  <= grant_mem & req_misalign;
                k         <= 2'd0;
                asm_data  <= 32'd0;
            end else begin
                if (xfer) begin
                    k <= k + 2'd1;
                end
                if (cap_en) begin
                    asm_data[{cap_idx, 3'b000} +: 8] <= bus.ram_din_i;
                end
            end
        end
    end

    always_comb begin
        load_ext = asm_data;
        if (width == 2'd0) begin
            load_ext = {{24{sgn & asm_data[7]}}, asm_data[7:0]};
        end else if (width == 2'd1) begin
            load_ext = {{16{sgn & asm_data[15]}}, asm_data[15:0]};
        end
    end

    // Base + k truncates to ADDR_W bits, giving the required address wrap.
    assign bus.ram_a_o    = xfer ? (base + ADDR_W'(k)) : '0;
    assign bus.ram_wr_o   = xfer & we;
    assign bus.ram_dout_o = (xfer && we) ? wdata[{k, 3'b000} +: 8] : 8'h00;

    assign if_done  = (state == DONE) && !owner_mem && !bus.if_cancel_i;
    assign mem_done = (state == DONE) && owner_mem;

    assign bus.if_done_o   = if_done;
    assign bus.if_data_o   = if_done ? asm_data : 32'd0;
    assign bus.mem_done_o  = mem_done;
    assign bus.mem_rdata_o = (mem_done && !misalign) ? load_ext : 32'd0;

`ifdef MEM_ARB_ALIGN_CHECK_EN
    assign bus.mem_misalign_o = mem_done && misalign;
`endif

    // Reset forces every output low, including the stall.
    assign bus.stall_req_o = !rst && ((bus.if_req_i && !if_done) ||
                                      (bus.mem_req_i && !mem_done));

endmodule
